// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store unit driving a req/gnt/rvalid byte-addressed data memory port
module lsu_mem_master #(
  parameter int ADDR_W       = 32,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] LP_CNT_LAST = 8'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_is_load;
  logic [2:0]        r_func3;
  logic [1:0]        r_off;
  logic [ADDR_W-3:0] r_waddr;
  logic [31:0]       r_sdata;
  logic              r_mis;
  logic              r_bus;
  logic [7:0]        r_cnt;
  logic [31:0]       r_load_data;

  logic        w_illegal;
  logic        w_misalign;
  logic        w_timeout;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Operation legality is judged on the live inputs in the accept cycle
  always_comb begin
    w_illegal  = (is_load == is_store)
               || (is_load && (func3 == 3'b011 || func3[2:1] == 2'b11))
               || (is_store && func3 > 3'b010);
    w_misalign = (func3[1:0] == 2'b01 && addr[0])
               || (func3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  end

  // The last RESP cycle is the one where the counter would reach RESP_TIMEOUT
  assign w_timeout = (r_cnt == LP_CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    mem_req      = 1'b0;
    misalign_err = 1'b0;
    bus_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = (w_illegal || w_misalign) ? S_FIN : S_REQ;
      end
      S_REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) w_state_nxt = r_is_load ? S_RESP : S_FIN;
      end
      S_RESP: begin
        busy = 1'b1;
        if (mem_rvalid || w_timeout) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        busy         = 1'b1;
        done         = 1'b1;
        misalign_err = r_mis;
        bus_err      = r_bus;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    if (!r_is_load) begin
      case (r_func3[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << r_off;
          w_wdata = {4{r_sdata[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << r_off;
          w_wdata = {2{r_sdata[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = r_sdata;
        end
      endcase
    end
  end

  assign mem_we    = mem_req & ~r_is_load;
  assign mem_addr  = mem_req ? {r_waddr, 2'b00} : '0;
  assign mem_wstrb = mem_req ? w_wstrb : 4'b0000;
  assign mem_wdata = mem_req ? w_wdata : 32'h0;

  always_comb begin
    case (r_off)
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_func3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_ext = mem_rdata;
      3'b100:  w_ext = {24'h0, w_byte};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = 32'h0;
    endcase
  end

  // load_data only changes on a load response or a load timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_is_load   <= 1'b0;
      r_func3     <= 3'b000;
      r_off       <= 2'b00;
      r_waddr     <= '0;
      r_sdata     <= 32'h0;
      r_mis       <= 1'b0;
      r_bus       <= 1'b0;
      r_cnt       <= 8'h0;
      r_load_data <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_is_load <= is_load;
            r_func3   <= func3;
            r_off     <= addr[1:0];
            r_waddr   <= addr[ADDR_W-1:2];
            r_sdata   <= store_data;
            r_mis     <= w_illegal || w_misalign;
            r_bus     <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_gnt) r_cnt <= 8'h0;
        end
        S_RESP: begin
          r_cnt <= r_cnt + 8'd1;
          if (mem_rvalid) begin
            r_load_data <= w_ext;
          end else if (w_timeout) begin
            r_load_data <= 32'h0;
            r_bus       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_data = r_load_data;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - self-checking bench for lsu_mem_master against an arithmetic reference model
module tb_lsu_mem_master;

  localparam int ADDR_W = 32;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              is_load;
  logic              is_store;
  logic [2:0]        func3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       store_data;
  logic              busy;
  logic              done;
  logic [31:0]       load_data;
  logic              misalign_err;
  logic              bus_err;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_last = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(ADDR_W), .RESP_TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .func3(func3),
    .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .load_data(load_data),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit op_bad(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (ld == st) return 1'b1;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (st && f3 > 3'd2) return 1'b1;
    sz = 1 << f3[1:0];
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = 1 << f3[1:0];
    return 4'(((1 << sz) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return d[7:0] * 32'h0101_0101;
      2'd1:    return d[15:0] * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int          sz;
    logic [31:0] mask;
    logic [31:0] v;
    sz   = 1 << f3[1:0];
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v    = (rd >> (8 * int'(a[1:0]))) & mask;
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic scramble_inputs();
    req_valid  = 1'($urandom_range(0, 1));
    is_load    = 1'($urandom_range(0, 1));
    is_store   = 1'($urandom_range(0, 1));
    func3      = 3'($urandom_range(0, 7));
    addr       = $urandom;
    store_data = $urandom;
  endtask

  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input int gw, input int rw, input logic [31:0] rd);
    bit          bad;
    logic [31:0] exp_ld;
    int          nw;
    bad    = op_bad(ld, st, f3, a);
    exp_ld = model_load(f3, a, rd);
    nw     = (rw < TO) ? rw : TO;
    check("idle_ready", req_ready, 1);
    req_valid = 1'b1; is_load = ld; is_store = st; func3 = f3; addr = a; store_data = sd;
    step();
    scramble_inputs();
    if (bad) begin
      check("err_done", done, 1);
      check("err_misalign", misalign_err, 1);
      check("err_bus", bus_err, 0);
      check("err_no_req", mem_req, 0);
    end else begin
      for (int i = 0; i <= gw; i++) begin
        mem_gnt = (i == gw);
        check("req_mem_req", mem_req, 1);
        check("req_we", mem_we, !ld);
        check("req_addr", mem_addr, {a[31:2], 2'b00});
        check("req_wstrb", mem_wstrb, ld ? 4'b0000 : model_strb(f3, a));
        if (!ld) check("req_wdata", mem_wdata, model_wdata(f3, sd));
        check("req_busy", busy, 1);
        check("req_done", done, 0);
        step();
        if (i != gw) scramble_inputs();
      end
      mem_gnt = 1'b0;
      if (!ld) begin
        check("st_done", done, 1);
        check("st_misalign", misalign_err, 0);
        check("st_bus", bus_err, 0);
      end else begin
        for (int i = 0; i < nw; i++) begin
          check("resp_done", done, 0);
          check("resp_mem_req", mem_req, 0);
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
          step();
        end
        if (rw < TO) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd;
          step();
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
          check("ld_done", done, 1);
          check("ld_data", load_data, exp_ld);
          check("ld_bus", bus_err, 0);
          check("ld_misalign", misalign_err, 0);
          exp_last = exp_ld;
        end else begin
          check("to_done", done, 1);
          check("to_bus", bus_err, 1);
          check("to_data", load_data, 0);
          check("to_misalign", misalign_err, 0);
          exp_last = 32'h0;
        end
      end
    end
    req_valid = 1'b0;
    step();
    check("post_done", done, 0);
    check("post_ready", req_ready, 1);
    check("post_busy", busy, 0);
    if (ld && !bad) check("ld_hold", load_data, exp_last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          ld, st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          k, r;
    rst_n = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; func3 = 3'b000;
    addr = '0; store_data = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_wstrb", mem_wstrb, 0);
    check("rst_load_data", load_data, 0);
    check("rst_errs", {misalign_err, bus_err}, 0);
    rst_n = 1'b1;
    step();

    do_op(0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 3, 0, 0);
    do_op(0, 1, 3'd0, 32'h13, 32'h0000_00A5, 0, 0, 0);
    do_op(0, 1, 3'd1, 32'h12, 32'h0000_1234, 1, 0, 0);
    do_op(1, 0, 3'd0, 32'h01, 0, 0, 0, 32'h80FF_7F01);
    do_op(1, 0, 3'd0, 32'h03, 0, 0, 0, 32'h80FF_7F01);
    do_op(1, 0, 3'd4, 32'h02, 0, 0, 0, 32'h80FF_7F01);
    do_op(1, 0, 3'd1, 32'h02, 0, 0, 0, 32'h80FF_7F01);
    do_op(1, 0, 3'd5, 32'h02, 0, 0, 0, 32'h80FF_7F01);
    do_op(1, 0, 3'd2, 32'h00, 0, 0, 0, 32'h80FF_7F01);
    do_op(1, 0, 3'd2, 32'h06, 0, 0, 0, 0);
    do_op(1, 0, 3'd1, 32'h05, 0, 0, 0, 0);
    do_op(1, 0, 3'd3, 32'h00, 0, 0, 0, 0);
    do_op(1, 1, 3'd0, 32'h00, 0, 0, 0, 0);
    do_op(0, 0, 3'd0, 32'h00, 0, 0, 0, 0);
    do_op(0, 1, 3'd3, 32'h00, 0, 0, 0, 0);
    do_op(1, 0, 3'd2, 32'h20, 0, 0, TO, 32'h1111_2222);
    do_op(1, 0, 3'd2, 32'h24, 0, 2, TO - 1, 32'h3333_4444);
    do_op(0, 1, 3'd2, 32'h28, 32'h5555_6666, 0, 0, 0);

    // Reset while a load waits for its response
    req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; func3 = 3'd2; addr = 32'h40;
    step();
    req_valid = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_ready", req_ready, 1);
    check("midrst_done", done, 0);
    check("midrst_mem_req", mem_req, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    check("late_rvalid_done", done, 0);
    check("late_rvalid_ready", req_ready, 1);
    step();
    check("late_rvalid_done2", done, 0);
    check("late_rvalid_data", load_data, 0);
    exp_last = 32'h0;

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 15);
      if (k == 0) begin
        ld = 1'($urandom_range(0, 1));
        st = ld;
      end else begin
        ld = (k < 9);
        st = !ld;
      end
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (ld) begin
        r = $urandom_range(0, 4);
        f3 = (r < 3) ? 3'(r) : 3'(r + 1);
      end else f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 1) == 1 && f3[1:0] != 2'b11) a = a & ~((32'h1 << f3[1:0]) - 32'h1);
      r = $urandom_range(0, 19);
      do_op(ld, st, f3, a, $urandom, $urandom_range(0, 3), (r < 12) ? (r % 4) : r, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
